systolic_skew_feeder: RTL and testbench

- Input staging stage directly upstream of a row of PE cells in the systolic array.
- Accepts one vector of LANES 32-bit float words per beat over a valid/ready handshake.
- Re-times the vector so lane k is presented k cycles after lane 0. This produces the diagonal wavefront the PE array needs.
- After the last vector of a block, the stage inserts zero bubbles until the wavefront drains, then pulses done.

---
 rtl/systolic_skew_feeder.sv | 117 +++++++++++
 tb/tb_systolic_skew_feeder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Skews one LANES-wide vector per beat into a diagonal wavefront for a PE row, then drains.
// Define FEEDER_STATS_EN to add vec_count, a count of accepted beats since reset.
module systolic_skew_feeder #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_data,
    input  logic                in_last,
    output logic [LANES*DW-1:0] x_out,
    output logic [LANES-1:0]    x_valid,
    output logic                busy,
`ifdef FEEDER_STATS_EN
    output logic [31:0]         vec_count,
`endif
    output logic                done
);

    localparam int unsigned   CW      = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] CntLast = (LANES > 1) ? CW'(LANES - 2) : '0;

    typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

    state_e        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_done, w_done_next;
    logic          w_accept;

    assign in_ready = ~rst & (r_state != StFlush);
    assign w_accept = in_valid & in_ready;
    assign busy     = (r_state != StIdle);
    assign done     = r_done;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        case (r_state)
            StIdle, StStream: begin
                if (w_accept) begin
                    if (!in_last) begin
                        w_state_next = StStream;
                    end else if (LANES == 1) begin
                        // Single lane: the last element is already on x_out after this edge.
                        w_state_next = StIdle;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = StFlush;
                        w_cnt_next   = '0;
                    end
                end
            end
            StFlush: begin
                if (r_cnt == CntLast) begin
                    w_state_next = StIdle;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
        end
    end

    // Lane k is a (k+1)-deep chain; bubbles carry zero words so the PE MAC stays harmless.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [k:0]         r_v;
        logic [k:0][DW-1:0] r_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= '0;
                r_d <= '0;
            end else begin
                r_v[0] <= w_accept;
                r_d[0] <= w_accept ? in_data[k*DW +: DW] : '0;
                for (int i = 1; i <= k; i++) begin
                    r_v[i] <= r_v[i-1];
                    r_d[i] <= r_d[i-1];
                end
            end
        end

        assign x_out[k*DW +: DW] = r_d[k];
        assign x_valid[k]        = r_v[k];
    end

`ifdef FEEDER_STATS_EN
    logic [31:0] r_vec_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec_count <= '0;
        end else if (w_accept) begin
            r_vec_count <= r_vec_count + 32'd1;
        end
    end

    assign vec_count = r_vec_count;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (LANES=4): skew timing, done, refusals, reset, stats.
module tb_systolic_skew_feeder;

    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 32;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*DW-1:0] in_data;
    logic                in_last;
    logic [LANES*DW-1:0] x_out;
    logic [LANES-1:0]    x_valid;
    logic                busy;
    logic                done;
`ifdef FEEDER_STATS_EN
    logic [31:0]         vec_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    systolic_skew_feeder #(
        .LANES (LANES),
        .DW    (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .x_out    (x_out),
        .x_valid  (x_valid),
        .busy     (busy),
`ifdef FEEDER_STATS_EN
        .vec_count(vec_count),
`endif
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] wd(input int j, input int k);
        return 32'hA000_0000 + 32'(j * 256 + k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int j, input logic last);
        in_valid = 1'b1;
        in_last  = last;
        for (int k = 0; k < LANES; k++) in_data[k*DW +: DW] = wd(j, k);
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        #12;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0", in_ready);
        end
        n_checks++;
        if (x_valid !== '0 || x_out !== '0) begin
            n_fail++;
            $display("FAIL reset_lanes: got v=%b x=%h expected zero", x_valid, x_out);
        end
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done_busy: got done=%b busy=%b expected 0 0", done, busy);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0]       fw [LANES];
        logic [LANES*DW-1:0] exp_x;
        logic [LANES-1:0]    exp_v;
        fw[0] = 32'h3F80_0000;
        fw[1] = 32'h4000_0000;
        fw[2] = 32'h4040_0000;
        fw[3] = 32'h4080_0000;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = {fw[3], fw[2], fw[1], fw[0]};
        for (int n = 0; n < 5; n++) begin
            tick();
            drive_idle();
            exp_v = (n < LANES) ? LANES'(1 << n) : '0;
            exp_x = '0;
            if (n < LANES) exp_x[n*DW +: DW] = fw[n];
            n_checks++;
            if (x_valid !== exp_v || x_out !== exp_x) begin
                n_fail++;
                $display("FAIL single_lanes n=%0d: got v=%b x=%h expected v=%b x=%h",
                         n, x_valid, x_out, exp_v, exp_x);
            end
            n_checks++;
            if (done !== (n == 3)) begin
                n_fail++;
                $display("FAIL single_done n=%0d: got %b expected %b", n, done, n == 3);
            end
            n_checks++;
            if (in_ready !== (n >= 3) || busy !== (n < 3)) begin
                n_fail++;
                $display("FAIL single_ready_busy n=%0d: got rdy=%b busy=%b expected %b %b",
                         n, in_ready, busy, n >= 3, n < 3);
            end
        end
    endtask

    task automatic test_back_to_back();
        int                  acc [16];
        logic [LANES*DW-1:0] exp_x;
        logic [LANES-1:0]    exp_v;
        foreach (acc[e]) acc[e] = -1;
        acc[0] = 0;
        acc[1] = 1;
        acc[2] = 2;
        for (int n = 0; n < 8; n++) begin
            if (n < 3) drive_beat(n, n == 2);
            else drive_idle();
            tick();
            exp_x = '0;
            exp_v = '0;
            for (int k = 0; k < LANES; k++) begin
                if (n >= k && acc[n-k] >= 0) begin
                    exp_v[k]           = 1'b1;
                    exp_x[k*DW +: DW]  = wd(acc[n-k], k);
                end
            end
            n_checks++;
            if (x_valid !== exp_v || x_out !== exp_x) begin
                n_fail++;
                $display("FAIL b2b_lanes n=%0d: got v=%b x=%h expected v=%b x=%h",
                         n, x_valid, x_out, exp_v, exp_x);
            end
            n_checks++;
            if (done !== (n == 5)) begin
                n_fail++;
                $display("FAIL b2b_done n=%0d: got %b expected %b", n, done, n == 5);
            end
        end
    endtask

    task automatic test_gap();
        int                  acc [16];
        logic [LANES*DW-1:0] exp_x;
        logic [LANES-1:0]    exp_v;
        foreach (acc[e]) acc[e] = -1;
        acc[0] = 20;
        acc[2] = 21;
        for (int n = 0; n < 8; n++) begin
            if (n == 0) drive_beat(20, 1'b0);
            else if (n == 2) drive_beat(21, 1'b1);
            else drive_idle();
            tick();
            exp_x = '0;
            exp_v = '0;
            for (int k = 0; k < LANES; k++) begin
                if (n >= k && acc[n-k] >= 0) begin
                    exp_v[k]          = 1'b1;
                    exp_x[k*DW +: DW] = wd(acc[n-k], k);
                end
            end
            n_checks++;
            if (x_valid !== exp_v || x_out !== exp_x) begin
                n_fail++;
                $display("FAIL gap_lanes n=%0d: got v=%b x=%h expected v=%b x=%h",
                         n, x_valid, x_out, exp_v, exp_x);
            end
            n_checks++;
            if (done !== (n == 5)) begin
                n_fail++;
                $display("FAIL gap_done n=%0d: got %b expected %b", n, done, n == 5);
            end
        end
    endtask

    task automatic test_refused();
        int                  acc [16];
        logic [LANES*DW-1:0] exp_x;
        logic [LANES-1:0]    exp_v;
        logic                exp_rdy;
        foreach (acc[e]) acc[e] = -1;
        acc[0] = 10;
        acc[4] = 11;
        for (int n = 0; n < 9; n++) begin
            if (n == 0) drive_beat(10, 1'b1);
            else if (n <= 4) drive_beat(11, 1'b1);
            else drive_idle();
            tick();
            exp_x = '0;
            exp_v = '0;
            for (int k = 0; k < LANES; k++) begin
                if (n >= k && acc[n-k] >= 0) begin
                    exp_v[k]          = 1'b1;
                    exp_x[k*DW +: DW] = wd(acc[n-k], k);
                end
            end
            exp_rdy = !((n <= 2) || (n >= 4 && n <= 6));
            n_checks++;
            if (x_valid !== exp_v || x_out !== exp_x) begin
                n_fail++;
                $display("FAIL refused_lanes n=%0d: got v=%b x=%h expected v=%b x=%h",
                         n, x_valid, x_out, exp_v, exp_x);
            end
            n_checks++;
            if (done !== (n == 3 || n == 7)) begin
                n_fail++;
                $display("FAIL refused_done n=%0d: got %b expected %b", n, done,
                         n == 3 || n == 7);
            end
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL refused_ready n=%0d: got %b expected %b", n, in_ready, exp_rdy);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        drive_beat(30, 1'b1);
        tick();
        drive_idle();
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (x_valid !== '0 || x_out !== '0) begin
            n_fail++;
            $display("FAIL midrst_lanes: got v=%b x=%h expected zero", x_valid, x_out);
        end
        n_checks++;
        if (in_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ready_done: got rdy=%b done=%b expected 0 0", in_ready, done);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || x_valid !== '0) begin
                n_fail++;
                $display("FAIL midrst_after n=%0d: got done=%b v=%b expected 0 0000",
                         n, done, x_valid);
            end
            n_checks++;
            if (in_ready !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_idle n=%0d: got rdy=%b busy=%b expected 1 0",
                         n, in_ready, busy);
            end
        end
    endtask

`ifdef FEEDER_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (vec_count !== 32'd0) begin
            n_fail++;
            $display("FAIL stats_reset: got %0d expected 0", vec_count);
        end
        // Beats on edges 0,2,4,5,6 (last on 6); valid held but refused on 7..9.
        for (int n = 0; n < 10; n++) begin
            if (n == 1 || n == 3) drive_idle();
            else drive_beat(40 + n, n == 6);
            tick();
        end
        drive_idle();
        n_checks++;
        if (vec_count !== 32'd5) begin
            n_fail++;
            $display("FAIL stats_count: got %0d expected 5", vec_count);
        end
        tick();
        tick();
        n_checks++;
        if (vec_count !== 32'd5) begin
            n_fail++;
            $display("FAIL stats_hold: got %0d expected 5", vec_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_refused();
        test_reset_mid_flush();
`ifdef FEEDER_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
